dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the single-port synchronous data memory behind the MEM stage (s4) between two requesters: the CPU load/store path and a loader/debug port that initialises or inspects data memory while the core runs. The CPU has priority. An aging counter guarantees the loader a slot, and a lock lets the loader run uninterrupted bursts. When the CPU is denied, the block raises a stall so the pipeline freezes in s4.

## Interface
- `AW`, 12: word-address width of the data memory.
- `MAX_WAIT`, 8: consecutive denied loader cycles before the loader wins over the CPU (1..255).
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `cpu_req`, `cpu_we` input 1 each: CPU access request and write flag (s4).
- `cpu_addr` input AW, `cpu_wdata` input 32, `cpu_be` input 4: CPU word address, write data, byte enables.
- `cpu_gnt` output 1: CPU access issued this cycle.
- `cpu_stall` output 1: equals `cpu_req && !cpu_gnt`.
- `cpu_rvalid` output 1, `cpu_rdata` output 32: CPU read data valid, read data.
- `ldr_req`, `ldr_we`, `ldr_lock` input 1 each: loader request, write flag, burst lock.
- `ldr_addr` input AW, `ldr_wdata` input 32, `ldr_be` input 4: loader word address, write data, byte enables.
- `ldr_gnt` output 1: loader access issued this cycle.
- `ldr_rvalid` output 1, `ldr_rdata` output 32: loader read data valid, read data.
- `mem_en`, `mem_we` output 1 each: memory enable and write.
- `mem_addr` output AW, `mem_wdata` output 32, `mem_be` output 4: memory address, write data, byte enables.
- `mem_rdata` input 32: memory read data, valid one cycle after a read enable.

## Operation
- **States:** `NORMAL` and `LOCKED`. Also held: `wait_cnt` (8-bit, saturating) and `rd_owner` (the owner of the pending read).
- **Grant in `NORMAL`:**
  - `ldr_gnt = ldr_req && (!cpu_req || wait_cnt == MAX_WAIT)`.
  - `cpu_gnt = cpu_req && !ldr_gnt`.
- **Grant in `LOCKED`:**
  - `ldr_gnt = ldr_req`.
  - `cpu_gnt = cpu_req && !ldr_req`.
- **Memory port:**
  - The memory port is driven by the granted requester.
  - `mem_en = cpu_gnt | ldr_gnt`.
  - When `mem_en = 0`: `mem_we = 0`, `mem_be = 0`, and address/data are don't-care.
- **Transitions:**
  - `NORMAL` → `LOCKED` on `ldr_gnt && ldr_lock`.
  - `LOCKED` → `NORMAL` on `!ldr_req`, or on `ldr_gnt && !ldr_lock`.
  - Self-loop otherwise.
- **`wait_cnt`:**
  - Increments when `ldr_req && !ldr_gnt`, saturating at `MAX_WAIT`.
  - Clears when `ldr_gnt` or `!ldr_req`.
- **Read return:**
  - A granted read with `we = 0` sets the next-cycle `rvalid` of its owner.
  - `cpu_rdata` and `ldr_rdata` both carry `mem_rdata`; only the owner's `rvalid` qualifies it.
  - Writes produce no `rvalid`.
- **Simultaneous requests:** if both request with `wait_cnt < MAX_WAIT` in `NORMAL`, the CPU wins and the loader counter ages.
- **No double issue:** both grants high in the same cycle is illegal and must never occur.

## Timing
- **Grants:** combinational from the requests and the current state, in the same cycle. Zero added latency on the issue path.
- **Read latency:** `rvalid` is registered, exactly 1 cycle after grant. Back-to-back reads from alternating owners each get a correct, non-overlapping `rvalid`.
- **Request hold rule:** a requester holds `req` and its payload stable until its `gnt` is seen. `cpu_stall` freezes s4 for exactly the denied cycles.
- **Reset values (while `rst` is high):**
  - State `NORMAL`, `wait_cnt = 0`.
  - `cpu_rvalid = 0`, `ldr_rvalid = 0`.
  - Grants forced to 0, `mem_en = 0`, `cpu_stall = 0`.
- **Reset mid-read:** reset with a read outstanding drops that `rvalid`; it is never delivered.
- **Reset during `LOCKED`:** returns to `NORMAL`.
- **`MAX_WAIT`:** the loader is starved for at most `MAX_WAIT` consecutive cycles.

## Structure
- **Shared package `dmem_arb_pkg`:**
  - `arb_state_e` enum (`NORMAL`, `LOCKED`).
  - `owner_e` enum (`OWN_CPU`, `OWN_LDR`).
  - `mem_req_t` packed struct (`we`, `addr`, `wdata`, `be`).
- **Sub-module `dmem_arb_age_cnt`:** the saturating wait counter, with inputs `inc`/`clr` and output `expired`.
- **Top level:** grant logic, the state register and the read-return pipeline. Instantiated between `u_data_mem_s4` and the s4 load/store unit in `cpu_top`.

## Test plan
- **CPU only:** CPU read at address `0x010` with memory holding `0xDEADBEEF`.
  - `cpu_gnt = 1` the same cycle, `cpu_rvalid = 1` with `0xDEADBEEF` the next cycle, `cpu_stall = 0` throughout.
- **Contention:** CPU and loader request continuously, `MAX_WAIT = 8`.
  - CPU is granted 8 cycles, the loader on the 9th, with `cpu_stall = 1` in that cycle.
  - The pattern repeats, and both grants are never high together.
- **Loader lock:** locked loader burst of 4 writes to `0x100`–`0x103` while the CPU requests.
  - 4 consecutive `ldr_gnt`, CPU stalled 4 cycles.
  - The lock drops on the 4th beat; the CPU is granted in cycle 5.
- **Interleaved reads:** CPU read at `0x020`, then loader read at `0x021` in the next cycle.
  - Two single-cycle pulses, `cpu_rvalid` then `ldr_rvalid`, each carrying its own word.
- **Reset mid-read:** `rst` asserted the cycle after a granted read.
  - `rvalid` stays 0, state returns to `NORMAL`, `wait_cnt = 0`.
- **Pass check:** full rv32ui-p-sw run with the loader idle.
  - The test passes with a cycle count identical to the run without the arbiter.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the s4 data-memory port arbiter: arbiter state, read owner and the
// per-requester access bundle that is muxed onto the memory port.
package dmem_arb_pkg;

    localparam int unsigned MAX_AW = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic {
        NORMAL,
        LOCKED
    } arb_state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_LDR
    } owner_e;

    // Address is carried at the widest supported width; the top narrows it back to AW.
    typedef struct packed {
        logic              we;
        logic [MAX_AW-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

    function automatic mem_req_t mk_req(input logic              we,
                                        input logic [MAX_AW-1:0] addr,
                                        input logic [DATA_W-1:0] wdata,
                                        input logic [BE_W-1:0]   be);
        mem_req_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        r.be    = be;
        return r;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, loader and memory-side signals around the data-memory arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface dmem_port_arbiter_if #(
    parameter int unsigned AW = 12
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [3:0]    cpu_be;
    logic          cpu_gnt;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [31:0]   cpu_rdata;

    logic          ldr_req;
    logic          ldr_we;
    logic          ldr_lock;
    logic [AW-1:0] ldr_addr;
    logic [31:0]   ldr_wdata;
    logic [3:0]    ldr_be;
    logic          ldr_gnt;
    logic          ldr_rvalid;
    logic [31:0]   ldr_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata, ldr_be,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata, ldr_be,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arb_age_cnt.sv
// Saturating count of consecutive cycles the loader has been denied; expired bounds
// how long the CPU may keep the loader starved.
module dmem_arb_age_cnt #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != 8'(MAX_WAIT))) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 8'(MAX_WAIT));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port s4 data memory between the CPU (priority) and the loader/debug
// port, with loader aging, burst lock and a one-cycle registered read-return path.
module dmem_port_arbiter #(
    parameter int unsigned AW       = 12,
    parameter int unsigned MAX_WAIT = 8
) (
    input logic               clk,
    input logic               rst,
    dmem_port_arbiter_if.slave bus
);
    import dmem_arb_pkg::*;

    arb_state_e state_q, state_d;
    owner_e     rd_owner_q, rd_owner_d;
    logic       rd_pend_q, rd_pend_d;
    logic       cpu_gnt, ldr_gnt;
    logic       age_inc, age_clr, expired;
    mem_req_t   cpu_r, ldr_r, sel;
    logic       unused_addr;

    dmem_arb_age_cnt #(
        .MAX_WAIT(MAX_WAIT)
    ) u_age_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (age_inc),
        .clr    (age_clr),
        .expired(expired)
    );

    // Grants are purely combinational so the issue path adds no latency.
    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        state_d = state_q;
        if (!rst) begin
            case (state_q)
                NORMAL: begin
                    ldr_gnt = bus.ldr_req && (!bus.cpu_req || expired);
                    cpu_gnt = bus.cpu_req && !ldr_gnt;
                    if (ldr_gnt && bus.ldr_lock) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    ldr_gnt = bus.ldr_req;
                    cpu_gnt = bus.cpu_req && !bus.ldr_req;
                    if (!bus.ldr_req || !bus.ldr_lock) begin
                        state_d = NORMAL;
                    end
                end
                default: state_d = NORMAL;
            endcase
        end
    end

    assign age_inc = bus.ldr_req && !ldr_gnt;
    assign age_clr = ldr_gnt || !bus.ldr_req;

    always_comb begin
        cpu_r = mk_req(bus.cpu_we, MAX_AW'(bus.cpu_addr), bus.cpu_wdata, bus.cpu_be);
        ldr_r = mk_req(bus.ldr_we, MAX_AW'(bus.ldr_addr), bus.ldr_wdata, bus.ldr_be);
        sel   = ldr_gnt ? ldr_r : cpu_r;
    end

    assign bus.mem_en    = cpu_gnt | ldr_gnt;
    assign bus.mem_we    = bus.mem_en & sel.we;
    assign bus.mem_be    = bus.mem_en ? sel.be : 4'b0000;
    assign bus.mem_addr  = sel.addr[AW-1:0];
    assign bus.mem_wdata = sel.wdata;
    assign unused_addr   = ^sel.addr;

    assign rd_pend_d  = bus.mem_en && !sel.we;
    assign rd_owner_d = ldr_gnt ? OWN_LDR : OWN_CPU;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= NORMAL;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CPU;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Masking with rst drops a read that was in flight when reset arrived.
    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.ldr_gnt    = ldr_gnt;
    assign bus.cpu_stall  = bus.cpu_req && !cpu_gnt && !rst;
    assign bus.cpu_rvalid = rd_pend_q && (rd_owner_q == OWN_CPU) && !rst;
    assign bus.ldr_rvalid = rd_pend_q && (rd_owner_q == OWN_LDR) && !rst;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.ldr_rdata  = bus.mem_rdata;

    no_double_issue: assert property (@(posedge clk) !(cpu_gnt && ldr_gnt));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a memory model behind the port, a read-data
// scoreboard fed at grant time, and one task per scenario with inline grant checks.
module tb_dmem_port_arbiter;

    localparam int unsigned AW       = 12;
    localparam int unsigned MAX_WAIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.AW(AW)) bus ();

    dmem_port_arbiter #(
        .AW      (AW),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] mem     [0:4095];
    logic [31:0] exp_mem [0:4095];
    logic [31:0] cpu_q[$];
    logic [31:0] ldr_q[$];
    int checks = 0;
    int errors = 0;

    // Synchronous single-port memory behind the arbiter.
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    // Scoreboard: expected read data is queued at grant and must return exactly one cycle later.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (rst) begin
            checks++;
            if (bus.cpu_gnt !== 1'b0 || bus.ldr_gnt !== 1'b0 || bus.mem_en !== 1'b0 ||
                bus.cpu_stall !== 1'b0 || bus.cpu_rvalid !== 1'b0 || bus.ldr_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs gnt=%b%b mem_en=%b stall=%b rvalid=%b%b required all 0",
                         bus.cpu_gnt, bus.ldr_gnt, bus.mem_en, bus.cpu_stall,
                         bus.cpu_rvalid, bus.ldr_rvalid);
            end
            cpu_q.delete();
            ldr_q.delete();
        end else begin
            if (cpu_q.size() != 0 || bus.cpu_rvalid !== 1'b0) begin
                checks++;
                if (cpu_q.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_rvalid_spurious got rvalid=%b required 0", bus.cpu_rvalid);
                end else begin
                    e = cpu_q.pop_front();
                    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== e) begin
                        errors++;
                        $display("FAIL cpu_read_return got rvalid=%b data=%h required 1 %h",
                                 bus.cpu_rvalid, bus.cpu_rdata, e);
                    end
                end
            end
            if (ldr_q.size() != 0 || bus.ldr_rvalid !== 1'b0) begin
                checks++;
                if (ldr_q.size() == 0) begin
                    errors++;
                    $display("FAIL ldr_rvalid_spurious got rvalid=%b required 0", bus.ldr_rvalid);
                end else begin
                    e = ldr_q.pop_front();
                    if (bus.ldr_rvalid !== 1'b1 || bus.ldr_rdata !== e) begin
                        errors++;
                        $display("FAIL ldr_read_return got rvalid=%b data=%h required 1 %h",
                                 bus.ldr_rvalid, bus.ldr_rdata, e);
                    end
                end
            end
            checks++;
            if ((bus.cpu_gnt && bus.ldr_gnt) || bus.cpu_stall !== (bus.cpu_req && !bus.cpu_gnt) ||
                bus.mem_en !== (bus.cpu_gnt | bus.ldr_gnt) ||
                (!bus.mem_en && (bus.mem_we !== 1'b0 || bus.mem_be !== 4'b0000))) begin
                errors++;
                $display("FAIL port_consistency gnt=%b%b req=%b stall=%b en=%b we=%b be=%b",
                         bus.cpu_gnt, bus.ldr_gnt, bus.cpu_req, bus.cpu_stall, bus.mem_en,
                         bus.mem_we, bus.mem_be);
            end
            if (bus.cpu_gnt === 1'b1) begin
                if (bus.cpu_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.cpu_be[b]) exp_mem[bus.cpu_addr][8*b +: 8] = bus.cpu_wdata[8*b +: 8];
                end else begin
                    cpu_q.push_back(exp_mem[bus.cpu_addr]);
                end
            end
            if (bus.ldr_gnt === 1'b1) begin
                if (bus.ldr_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.ldr_be[b]) exp_mem[bus.ldr_addr][8*b +: 8] = bus.ldr_wdata[8*b +: 8];
                end else begin
                    ldr_q.push_back(exp_mem[bus.ldr_addr]);
                end
            end
        end
    end

    task automatic drive_cpu(input logic req, input logic we, input logic [11:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_be    = be;
    endtask

    task automatic drive_ldr(input logic req, input logic we, input logic lock,
                             input logic [11:0] addr, input logic [31:0] wdata);
        bus.ldr_req   = req;
        bus.ldr_we    = we;
        bus.ldr_lock  = lock;
        bus.ldr_addr  = addr;
        bus.ldr_wdata = wdata;
        bus.ldr_be    = 4'hF;
    endtask

    task automatic idle();
        drive_cpu(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        drive_ldr(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_cpu(1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
        drive_ldr(1'b1, 1'b0, 1'b1, 12'h011, 32'h0);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.cpu_gnt !== 1'b0 || bus.ldr_gnt !== 1'b0 || bus.mem_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_grants got gnt=%b%b en=%b required 000",
                         bus.cpu_gnt, bus.ldr_gnt, bus.mem_en);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        @(negedge clk);
    endtask

    task automatic test_cpu_only();
        @(posedge clk); #1;
        drive_cpu(1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.ldr_gnt !== 1'b0) begin
            errors++;
            $display("FAIL cpu_only_gnt got gnt=%b stall=%b required 1 0", bus.cpu_gnt, bus.cpu_stall);
        end
        @(posedge clk); #1;
        drive_cpu(1'b1, 1'b1, 12'h011, 32'h1234_5678, 4'b0011);
        @(negedge clk);
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEAD_BEEF || bus.cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL cpu_only_rdata got rvalid=%b data=%h required 1 deadbeef",
                     bus.cpu_rvalid, bus.cpu_rdata);
        end
        @(posedge clk); #1;
        drive_cpu(1'b1, 1'b0, 12'h011, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL write_no_rvalid got rvalid=%b gnt=%b required 0 1", bus.cpu_rvalid, bus.cpu_gnt);
        end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hA500_5678) begin
            errors++;
            $display("FAIL byte_enable_write got rvalid=%b data=%h required 1 a5005678",
                     bus.cpu_rvalid, bus.cpu_rdata);
        end
    endtask

    task automatic test_contention();
        int cpu_n = 0;
        int ldr_n = 0;
        logic exp_l;
        for (int i = 0; i < 27; i++) begin
            @(posedge clk); #1;
            drive_cpu(1'b1, 1'b0, 12'(12'h200 + cpu_n), 32'h0, 4'hF);
            drive_ldr(1'b1, 1'b1, 1'b0, 12'(12'h300 + ldr_n), 32'hB000_0000 + 32'(ldr_n));
            @(negedge clk);
            exp_l = ((i % 9) == 8);
            checks++;
            if (bus.ldr_gnt !== exp_l || bus.cpu_gnt !== !exp_l || bus.cpu_stall !== exp_l) begin
                errors++;
                $display("FAIL contention_cycle%0d got cpu_gnt=%b ldr_gnt=%b stall=%b required %b %b %b",
                         i, bus.cpu_gnt, bus.ldr_gnt, bus.cpu_stall, !exp_l, exp_l, exp_l);
            end
            if (bus.cpu_gnt === 1'b1) cpu_n++;
            if (bus.ldr_gnt === 1'b1) ldr_n++;
        end
        @(posedge clk); #1;
        idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lock();
        int cpu_n = 0;
        int beat = 0;
        logic exp_l;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            drive_cpu(1'b1, 1'b0, 12'(12'h040 + cpu_n), 32'h0, 4'hF);
            if (beat < 4) drive_ldr(1'b1, 1'b1, beat < 3, 12'(12'h100 + beat), 32'hC0DE_0000 + 32'(beat));
            else drive_ldr(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
            @(negedge clk);
            exp_l = (i >= 8 && i <= 11);
            checks++;
            if (bus.ldr_gnt !== exp_l || bus.cpu_gnt !== !exp_l || bus.cpu_stall !== exp_l) begin
                errors++;
                $display("FAIL lock_cycle%0d got cpu_gnt=%b ldr_gnt=%b stall=%b required %b %b %b",
                         i, bus.cpu_gnt, bus.ldr_gnt, bus.cpu_stall, !exp_l, exp_l, exp_l);
            end
            if (bus.cpu_gnt === 1'b1) cpu_n++;
            if (bus.ldr_gnt === 1'b1) beat++;
        end
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i < 4) drive_cpu(1'b1, 1'b0, 12'(12'h100 + i), 32'h0, 4'hF);
            else idle();
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hC0DE_0000 + 32'(i - 1)) begin
                    errors++;
                    $display("FAIL burst_readback%0d got rvalid=%b data=%h required 1 %h", i - 1,
                             bus.cpu_rvalid, bus.cpu_rdata, 32'hC0DE_0000 + 32'(i - 1));
                end
            end
        end
    endtask

    task automatic test_interleaved();
        @(posedge clk); #1;
        drive_cpu(1'b1, 1'b0, 12'h020, 32'h0, 4'hF);
        @(negedge clk);
        @(posedge clk); #1;
        drive_cpu(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        drive_ldr(1'b1, 1'b0, 1'b0, 12'h021, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.ldr_gnt !== 1'b1 || bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hA500_0020 ||
            bus.ldr_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL interleave_cpu got ldr_gnt=%b rvalid=%b%b data=%h required 1 10 a5000020",
                     bus.ldr_gnt, bus.cpu_rvalid, bus.ldr_rvalid, bus.cpu_rdata);
        end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        checks++;
        if (bus.ldr_rvalid !== 1'b1 || bus.ldr_rdata !== 32'hA500_0021 || bus.cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL interleave_ldr got rvalid=%b%b data=%h required 01 a5000021",
                     bus.cpu_rvalid, bus.ldr_rvalid, bus.ldr_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        int cpu_n = 0;
        // Locked loader read in flight when reset arrives.
        @(posedge clk); #1;
        drive_ldr(1'b1, 1'b0, 1'b1, 12'h030, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.ldr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL lock_read_gnt got %b required 1", bus.ldr_gnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ldr_rvalid !== 1'b0 || bus.ldr_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_drops_read got rvalid=%b gnt=%b required 0 0", bus.ldr_rvalid, bus.ldr_gnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive_cpu(1'b1, 1'b0, 12'h050, 32'h0, 4'hF);
        drive_ldr(1'b1, 1'b0, 1'b0, 12'h031, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.ldr_gnt !== 1'b0 || bus.ldr_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_leaves_locked got cpu_gnt=%b ldr_gnt=%b ldr_rvalid=%b required 1 0 0",
                     bus.cpu_gnt, bus.ldr_gnt, bus.ldr_rvalid);
        end
        cpu_n = 1;
        // Age the loader, then reset with a CPU read outstanding; aging must restart from zero.
        repeat (2) begin
            @(posedge clk); #1;
            drive_cpu(1'b1, 1'b0, 12'(12'h050 + cpu_n), 32'h0, 4'hF);
            @(negedge clk);
            cpu_n++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drops_cpu_read got rvalid=%b required 0", bus.cpu_rvalid);
        end
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            drive_cpu(1'b1, 1'b0, 12'(12'h050 + cpu_n), 32'h0, 4'hF);
            @(negedge clk);
            checks++;
            if (bus.ldr_gnt !== (i == 8) || bus.cpu_gnt !== (i != 8)) begin
                errors++;
                $display("FAIL wait_cnt_cleared_cycle%0d got cpu_gnt=%b ldr_gnt=%b required %b %b",
                         i, bus.cpu_gnt, bus.ldr_gnt, (i != 8), (i == 8));
            end
            if (bus.cpu_gnt === 1'b1) cpu_n++;
        end
        @(posedge clk); #1;
        idle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = {8'hA5, 12'h000, 12'(i)};
            exp_mem[i] = {8'hA5, 12'h000, 12'(i)};
        end
        mem[16]     = 32'hDEAD_BEEF;
        exp_mem[16] = 32'hDEAD_BEEF;
        idle();
        test_reset();
        test_cpu_only();
        test_contention();
        test_lock();
        test_interleaved();
        test_reset_mid_read();
        checks++;
        if (cpu_q.size() != 0 || ldr_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d %0d pending required 0 0", cpu_q.size(), ldr_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
